therm_simple_memory_responder: RTL

THERM_SIMPLE_MEMORY_RESPONDER -- requirements
Module: therm_simple_memory_responder

---
 rtl/therm_simple_memory_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/therm_simple_memory_responder.sv
// rtl/therm_simple_memory_responder.sv - single-port dword memory responder with wait states
//
// Purpose: services one load/store at a time from a DEPTH x 64 array. A request
// is captured in IDLE, optionally waits WAIT_STATES cycles, and completes with a
// one-cycle ready pulse in DONE. Dropping chip_enable during WAIT aborts the access.
//
// Optional feature macro: THERM_MEM_FAULT_EN
//   defined   : captured addresses >= DEPTH complete with fault=1, no write, data_load=0
//   undefined : no fault port, addresses wrap modulo DEPTH
//
// Ports:
//   clock         in   1   rising-edge clock
//   reset_neg     in   1   asynchronous active-low reset
//   chip_enable   in   1   request valid, held until ready
//   write_enable  in   1   1 = store, 0 = load
//   address       in   64  dword index
//   data_store    in   64  store data
//   data_load     out  64  load data, held until the next completed load
//   ready         out  1   completion pulse (DONE cycle)
//   fault         out  1   out-of-range pulse (THERM_MEM_FAULT_EN only)

module therm_simple_memory_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_neg,
  input  logic        chip_enable,
  input  logic        write_enable,
  input  logic [63:0] address,
  input  logic [63:0] data_store,
  output logic [63:0] data_load,
  output logic        ready
`ifdef THERM_MEM_FAULT_EN
  ,
  output logic        fault
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        we_q;
  logic [63:0] data_load_q;

  logic [63:0] mem [DEPTH];

  logic          capture;
  logic          enter_done;
  logic [63:0]   acc_addr;
  logic [63:0]   acc_wdata;
  logic          acc_we;
  logic          acc_oob;
  logic [AW-1:0] acc_idx;

  // With zero wait states DONE is entered on the capture edge itself, so the
  // access must use the live inputs then; otherwise the latched copies.
  assign capture   = (state_q == S_IDLE) && chip_enable;
  assign acc_addr  = capture ? address      : addr_q;
  assign acc_wdata = capture ? data_store   : wdata_q;
  assign acc_we    = capture ? write_enable : we_q;
  assign acc_idx   = acc_addr[AW-1:0];

`ifdef THERM_MEM_FAULT_EN
  assign acc_oob = |acc_addr[63:AW];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[63:AW];
  assign acc_oob        = 1'b0;
`endif

  // Gated by reset so an access can never commit while reset is held.
  assign enter_done = reset_neg && (state_q != S_DONE) && (state_d == S_DONE);

  // State register
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (chip_enable) begin
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (!chip_enable) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    ready     = (state_q == S_DONE);
    data_load = data_load_q;
`ifdef THERM_MEM_FAULT_EN
    fault     = (state_q == S_DONE) && (|addr_q[63:AW]);
`endif
  end

  // Request capture and load data register
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      we_q        <= 1'b0;
      data_load_q <= 64'd0;
    end else begin
      if (capture) begin
        addr_q  <= address;
        wdata_q <= data_store;
        we_q    <= write_enable;
      end
      if (enter_done && !acc_we) begin
        data_load_q <= acc_oob ? 64'd0 : mem[acc_idx];
      end
    end
  end

  // Storage array: not reset, contents survive reset
  always_ff @(posedge clock) begin
    if (enter_done && acc_we && !acc_oob) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule
